// File: rtl/adder_nibble_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract that reuses one 4-bit ripple adder,
// one nibble per clock, with the inter-nibble carry held in carry_reg.

module FullAdder_4Bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end

endmodule

module adder_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             op_sub_reg;
  logic             carry_reg;
  logic [IW-1:0]    idx;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] fa_sum;
  logic       fa_cout;
  logic       last;
  logic       accept;

  assign a_nib  = a_reg[{idx, 2'b00} +: 4];
  assign b_nib  = b_reg[{idx, 2'b00} +: 4] ^ {4{op_sub_reg}};
  assign last   = (idx == LAST);
  assign accept = start && (state != RUN);

  FullAdder_4Bit u_fa (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_reg),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      op_sub_reg <= 1'b0;
      carry_reg  <= 1'b0;
      idx        <= '0;
      sum        <= '0;
      cout       <= 1'b0;
      ovf        <= 1'b0;
    end else if (accept) begin
      a_reg      <= a;
      b_reg      <= b;
      op_sub_reg <= op_sub;
      carry_reg  <= op_sub;
      idx        <= '0;
    end else if (state == RUN) begin
      sum[{idx, 2'b00} +: 4] <= fa_sum;
      carry_reg              <= fa_cout;
      idx                    <= last ? '0 : idx + 1'b1;
      if (last) begin
        cout <= fa_cout;
        // signed overflow: like-signed inputs, result sign differs
        ovf  <= (a_nib[3] == b_nib[3]) && (fa_sum[3] != a_nib[3]);
      end
    end
  end

endmodule

// File: tb/tb_adder_nibble_sequencer.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop on done.

module tb_adder_nibble_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        op_sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  logic        start4 = 1'b0;
  logic        op4 = 1'b0;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        busy4, done4, cout4, ovf4;
  logic [3:0]  sum4;

  adder_nibble_sequencer #(.WIDTH(16)) u16 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf)
  );

  adder_nibble_sequencer #(.WIDTH(4)) u4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start4),
    .op_sub (op4),
    .a      (a4),
    .b      (b4),
    .busy   (busy4),
    .done   (done4),
    .sum    (sum4),
    .cout   (cout4),
    .ovf    (ovf4)
  );

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        v;
    int          t;
  } exp_t;

  exp_t q16[$];
  exp_t q4[$];
  exp_t e16, e4;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int run16 = 0;
  int run4 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (q16.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w16_spurious_done got done=1 want 0 at cycle %0d",
                   cyc);
        end else begin
          e16 = q16.pop_front();
          chk("w16_sum", 32'(sum), 32'(e16.s));
          chk("w16_cout", 32'(cout), 32'(e16.c));
          chk("w16_ovf", 32'(ovf), 32'(e16.v));
          chk("w16_latency", 32'(cyc), 32'(e16.t));
          chk("w16_busy_len", 32'(run16), 32'd4);
        end
        run16 = 0;
      end else if (busy) run16++;
      else run16 = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (done4) begin
        if (q4.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w4_spurious_done got done=1 want 0 at cycle %0d",
                   cyc);
        end else begin
          e4 = q4.pop_front();
          chk("w4_sum", 32'(sum4), 32'(e4.s));
          chk("w4_cout", 32'(cout4), 32'(e4.c));
          chk("w4_ovf", 32'(ovf4), 32'(e4.v));
          chk("w4_latency", 32'(cyc), 32'(e4.t));
          chk("w4_busy_len", 32'(run4), 32'd1);
        end
        run4 = 0;
      end else if (busy4) run4++;
      else run4 = 0;
    end
  end

  task automatic issue16(input logic [15:0] ia, input logic [15:0] ib,
                         input logic iop, input logic [15:0] es,
                         input logic ec, input logic ev, input bit keep);
    a      = ia;
    b      = ib;
    op_sub = iop;
    start  = 1'b1;
    @(posedge clk);
    #1;
    q16.push_back('{es, ec, ev, cyc + 4});
    if (!keep) start = 1'b0;
  endtask

  task automatic issue4(input logic [3:0] ia, input logic [3:0] ib,
                        input logic iop, input logic [3:0] es,
                        input logic ec, input logic ev);
    a4     = ia;
    b4     = ib;
    op4    = iop;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    q4.push_back('{16'(es), ec, ev, cyc + 1});
    start4 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q16.size() == 0 && q4.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain_q16", 32'(q16.size()), 32'd0);
    chk("drain_q4", 32'(q4.size()), 32'd0);
    q16.delete();
    q4.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_done16();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("w16_done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_w4_flags", 32'({busy4, done4, cout4, ovf4}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue16(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    drain();
    issue16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    drain();
    issue16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    drain();
    issue16(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    drain();
    issue16(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    drain();

    issue16(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    q16.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_idle", 32'({busy, done}), 32'd0);

    issue16(16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    a     = 16'hAAAA;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();

    issue16(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
    wait_done16();
    issue16(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
    drain();

    issue16(16'h0100, 16'h0023, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b1);
    repeat (2) begin
      repeat (5) @(posedge clk);
      #1;
      q16.push_back('{16'h0123, 1'b0, 1'b0, cyc + 4});
    end
    start = 1'b0;
    drain();

    issue4(4'hE, 4'h9, 1'b0, 4'h7, 1'b1, 1'b1);
    drain();
    issue4(4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
